// File: rtl/prefix_sum_stage_if.sv
// Handshake bundle between the carry tree, the sum stage and its consumer.
// Upstream: in_valid/in_ready, p_in, g_grp, cin. Downstream: out_valid/out_ready, sum, cout, ovf, zero.
interface prefix_sum_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_grp;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, p_in, g_grp, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

    modport master (
        output in_valid, p_in, g_grp, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/prefix_sum_stage.sv
// Post-tree sum/flag stage with a 2-entry output FIFO behind valid/ready.
// Ports: clk, rst_n (sync, active-low), bus (slave side), result_cnt (pops since reset).
module prefix_sum_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    prefix_sum_stage_if.slave bus,
    output logic [CNT_W-1:0] result_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    entry_t           new_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] carry;
    logic             push;
    logic             pop;

    // Carry into bit i is the group generate of bits below it.
    always_comb begin
        carry      = {bus.g_grp[WIDTH-2:0], bus.cin};
        new_e.sum  = bus.p_in ^ carry;
        new_e.cout = bus.g_grp[WIDTH-1];
        new_e.ovf  = bus.g_grp[WIDTH-1] ^ bus.g_grp[WIDTH-2];
        new_e.zero = ~|(bus.p_in ^ carry);
    end

    assign bus.in_ready  = rst_n & (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, pop};
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_e;
                end else if (push) begin
                    tail_d  = new_e;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Head contents may be stale once drained, so gate with valid.
    assign bus.sum    = head_q.sum & {WIDTH{bus.out_valid}};
    assign bus.cout   = head_q.cout & bus.out_valid;
    assign bus.ovf    = head_q.ovf & bus.out_valid;
    assign bus.zero   = head_q.zero & bus.out_valid;
    assign result_cnt = cnt_q;

endmodule

// File: doc/prefix_sum_stage.md
# prefix_sum_stage

Registered post-processing stage that sits directly downstream of the parallel-prefix carry tree built from black/grey cells. It takes the bitwise propagate vector and the tree's group-generate (carry) vector, forms sum, carry-out, signed overflow and zero flags, and holds results in a 2-entry output buffer behind a valid/ready handshake. This buffer lets the combinational tree be decoupled from a stalling consumer.

## Interface
- WIDTH, 16, operand width in bits (≥2)
- CNT_W, 16, width of the accepted-result counter

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  upstream presents a valid p/g word
- in_ready  out  1  stage can accept a word this cycle
- p_in  in  WIDTH  bitwise propagate, p_in[i] = a[i]^b[i]
- g_grp  in  WIDTH  group generate G[i:0] from tree, cin already folded in; g_grp[i] = carry out of bit i
- cin  in  1  carry-in used by the tree
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- sum  out  WIDTH  head sum
- cout  out  1  head carry-out
- ovf  out  1  head signed overflow
- zero  out  1  head sum == 0
- result_cnt  out  CNT_W  number of results popped since reset

## Operation
- Carry into bit i: c[0] = cin; c[i] = g_grp[i-1] for i ≥ 1.
- sum[i] = p_in[i] ^ c[i]; cout = g_grp[WIDTH-1]; ovf = g_grp[WIDTH-1] ^ g_grp[WIDTH-2]; zero = (sum == 0).
- Results are computed combinationally from inputs and written to the buffer on push; outputs are driven only from buffer storage (no input-to-output combinational path).
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer: 2 entries, FIFO order, occupancy count ∈ {0,1,2}.
  - States EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE (head replaced by new entry).
  - FULL: pop → ONE; push impossible.
- in_ready = rst_n & (count != 2); depends only on registered state, not on out_ready.
- out_valid = (count != 0).
- result_cnt increments by 1 on every pop, wraps modulo 2^CNT_W.
- in_valid with in_ready low: word is not consumed; upstream must hold it.
- Outputs sum/cout/ovf/zero are 0 when out_valid is 0.

## Timing
- Reset (rst_n low at a rising edge): count = 0, out_valid = 0, sum = cout = ovf = zero = 0, result_cnt = 0; in_ready = 0 while rst_n is low.
- Reset mid-operation discards buffered entries; no pop is counted on the reset edge.
- Latency: word pushed at edge N is on outputs with out_valid = 1 after edge N (first visible in cycle N+1) when the buffer was empty.
- Throughput: 1 word/cycle sustained while out_ready stays high.
- After FULL, in_ready rises in the cycle after the first pop.
- out_valid held and head stable until popped (no data change while out_valid & !out_ready).

## Test plan
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0 (p/g from reference model), out_ready=1 -> one cycle later sum=0x5555, cout=0, ovf=0, zero=0, result_cnt=1.
- Overflow/carry: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0; a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0, zero=1.
- Back-pressure: out_ready=0, push 3 words -> in_ready drops after 2nd push, 3rd held; raise out_ready -> words emerge in order, result_cnt=3.
- Simultaneous push+pop in ONE state, 100 random back-to-back words with out_ready=1 -> no bubbles, in-order, all sums match a+b+cin.
- Reset mid-operation with buffer FULL -> next cycle out_valid=0, result_cnt=0, in_ready=1 after rst_n high.
- result_cnt wrap with CNT_W=4: 17 pops -> result_cnt=1.
